// File: rtl/edge_interval_if.sv
// Signal bundle for edge_interval_checker: s1/s2 event inputs, interval limit and
// the violation/measurement outputs.
interface edge_interval_if #(
  parameter int unsigned CNT_W = 16
);
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] lim;
  logic             vio;
  logic [15:0]      vio_cnt;
  logic [CNT_W-1:0] last_delta;

  modport master (
    output s1, s2, lim,
    input  vio, vio_cnt, last_delta
  );

  modport slave (
    input  s1, s2, lim,
    output vio, vio_cnt, last_delta
  );
endinterface

// File: rtl/edge_interval_checker.sv
// Measures clk cycles from an s1 event to the next s2 event and flags intervals shorter
// than lim; the violation pulse is stretched to VIO_HOLD cycles.
module edge_interval_checker #(
  parameter int unsigned CNT_W    = 16,
  parameter bit          S1_ANY   = 1'b0,
  parameter bit          S2_ANY   = 1'b0,
  parameter int unsigned VIO_HOLD = 2
) (
  input  logic          clk,
  input  logic          rst,
  edge_interval_if.slave bus_io
);

  localparam int unsigned      HoldW    = (VIO_HOLD > 1) ? $clog2(VIO_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(VIO_HOLD - 1);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic {StPrime, StRun} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             vio_q, vio_d;
  logic [15:0]      vio_cnt_q, vio_cnt_d;
  logic [CNT_W-1:0] last_delta_q, last_delta_d;
  logic             s1_ev, s2_ev, viol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StPrime;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      elapsed_q    <= '1;
      hold_q       <= '0;
      vio_q        <= 1'b0;
      vio_cnt_q    <= '0;
      last_delta_q <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= bus_io.s1;
      s2_q         <= bus_io.s2;
      elapsed_q    <= elapsed_d;
      hold_q       <= hold_d;
      vio_q        <= vio_d;
      vio_cnt_q    <= vio_cnt_d;
      last_delta_q <= last_delta_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s1_ev        = 1'b0;
    s2_ev        = 1'b0;
    viol         = 1'b0;
    elapsed_d    = elapsed_q;
    hold_d       = hold_q;
    vio_d        = vio_q;
    vio_cnt_d    = vio_cnt_q;
    last_delta_d = last_delta_q;

    unique case (state_q)
      // First edge after reset only captures the input levels.
      StPrime: state_d = StRun;
      StRun: begin
        s1_ev = S1_ANY ? (bus_io.s1 ^ s1_q) : (bus_io.s1 & ~s1_q);
        s2_ev = S2_ANY ? (bus_io.s2 ^ s2_q) : (bus_io.s2 & ~s2_q);
      end
      default: state_d = StPrime;
    endcase

    // s2 is judged against the old timestamp even when s1 fires on the same cycle.
    if (s2_ev) begin
      last_delta_d = elapsed_q;
      viol         = (elapsed_q < bus_io.lim);
    end

    if (s1_ev) begin
      elapsed_d = CntOne;
    end else if (elapsed_q != '1) begin
      elapsed_d = elapsed_q + CntOne;
    end

    if (viol) begin
      vio_d  = 1'b1;
      hold_d = HoldLoad;
      if (vio_cnt_q != 16'hFFFF) begin
        vio_cnt_d = vio_cnt_q + 16'd1;
      end
    end else if (vio_q) begin
      if (hold_q == '0) begin
        vio_d = 1'b0;
      end else begin
        hold_d = hold_q - HoldOne;
      end
    end
  end

  assign bus_io.vio        = vio_q;
  assign bus_io.vio_cnt    = vio_cnt_q;
  assign bus_io.last_delta = last_delta_q;

endmodule

// File: tb/tb_edge_interval_checker.sv
// Bench for edge_interval_checker: three parameter variants checked every cycle against a
// timestamp-based model, plus directed scenarios with literal expectations.
module tb_edge_interval_checker;

  localparam longint MaxVal = 65535;
  localparam longint Hold   = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // a: rising->rising, b: any->rising with s1 and s2 on one net, c: rising->any
  edge_interval_if #(.CNT_W(16)) bus_a ();
  edge_interval_if #(.CNT_W(16)) bus_b ();
  edge_interval_if #(.CNT_W(16)) bus_c ();

  assign bus_b.s2 = bus_b.s1;

  edge_interval_checker #(.CNT_W(16), .S1_ANY(1'b0), .S2_ANY(1'b0), .VIO_HOLD(2)) u_a (
    .clk(clk), .rst(rst), .bus_io(bus_a)
  );
  edge_interval_checker #(.CNT_W(16), .S1_ANY(1'b1), .S2_ANY(1'b0), .VIO_HOLD(2)) u_b (
    .clk(clk), .rst(rst), .bus_io(bus_b)
  );
  edge_interval_checker #(.CNT_W(16), .S1_ANY(1'b0), .S2_ANY(1'b1), .VIO_HOLD(2)) u_c (
    .clk(clk), .rst(rst), .bus_io(bus_c)
  );

  typedef struct packed {
    bit     primed;
    bit     p1;
    bit     p2;
    bit     seen;
    longint t1;
    longint n;
    longint vio_end;
    longint last_delta;
    int     vio_cnt;
  } model_t;

  model_t ma = '0;
  model_t mb = '0;
  model_t mc = '0;

  // Edge-indexed model: remembers when the last s1 event happened and when vio must drop.
  function automatic model_t step(model_t m, bit s1, bit s2, logic [15:0] lim,
                                  bit s1_any, bit s2_any);
    bit     e1, e2;
    longint d;
    m.n = m.n + 1;
    if (m.primed) begin
      e1 = s1_any ? (s1 != m.p1) : (s1 && !m.p1);
      e2 = s2_any ? (s2 != m.p2) : (s2 && !m.p2);
      if (e2) begin
        d = m.seen ? (m.n - m.t1) : MaxVal;
        if (d > MaxVal) d = MaxVal;
        m.last_delta = d;
        if (d < longint'(lim)) begin
          m.vio_end = m.n + Hold;
          if (m.vio_cnt < 65535) m.vio_cnt = m.vio_cnt + 1;
        end
      end
      if (e1) begin
        m.seen = 1'b1;
        m.t1   = m.n;
      end
    end
    m.primed = 1'b1;
    m.p1     = s1;
    m.p2     = s2;
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
      mc <= '0;
    end else begin
      ma <= step(ma, bus_a.s1, bus_a.s2, bus_a.lim, 1'b0, 1'b0);
      mb <= step(mb, bus_b.s1, bus_b.s2, bus_b.lim, 1'b1, 1'b0);
      mc <= step(mc, bus_c.s1, bus_c.s2, bus_c.lim, 1'b0, 1'b1);
    end
  end

  task automatic cmp(input string nm, input logic v, input logic [15:0] cnt,
                     input logic [15:0] dl, input model_t m);
    logic        ev;
    logic [15:0] ec, ed;
    ev = (m.n < m.vio_end);
    ec = 16'(m.vio_cnt);
    ed = 16'(m.last_delta);
    n_cmp++;
    if (v !== ev || cnt !== ec || dl !== ed) begin
      n_err++;
      $display("FAIL model_%s t=%0t: got vio=%b cnt=%0d delta=%0d, want vio=%b cnt=%0d delta=%0d",
               nm, $time, v, cnt, dl, ev, ec, ed);
    end
  endtask

  always @(negedge clk) begin
    cmp("a", bus_a.vio, bus_a.vio_cnt, bus_a.last_delta, ma);
    cmp("b", bus_b.vio, bus_b.vio_cnt, bus_b.last_delta, mb);
    cmp("c", bus_c.vio, bus_c.vio_cnt, bus_c.last_delta, mc);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Leaves the bench on the negedge right after the priming edge.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    bus_a.s1 = 1'b0;
    bus_a.s2 = 1'b0;
    bus_b.s1 = 1'b0;
    bus_c.s1 = 1'b0;
    bus_c.s2 = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst       = 1'b1;
    bus_a.s1  = 1'b0;
    bus_a.s2  = 1'b0;
    bus_a.lim = 16'd10;
    bus_b.s1  = 1'b0;
    bus_b.lim = 16'd3;
    bus_c.s1  = 1'b0;
    bus_c.s2  = 1'b0;
    bus_c.lim = 16'd10;
    cyc(1);
    chk("rst_vio", 32'(bus_a.vio), 32'd0);
    chk("rst_cnt", 32'(bus_a.vio_cnt), 32'd0);
    chk("rst_delta", 32'(bus_a.last_delta), 32'd0);

    // Short interval: 6 < 10
    do_reset();
    bus_a.s1 = 1'b1;
    cyc(6);
    bus_a.s2 = 1'b1;
    cyc(1);
    chk("t1_vio0", 32'(bus_a.vio), 32'd1);
    chk("t1_delta", 32'(bus_a.last_delta), 32'd6);
    chk("t1_cnt", 32'(bus_a.vio_cnt), 32'd1);
    cyc(1);
    chk("t1_vio1", 32'(bus_a.vio), 32'd1);
    cyc(1);
    chk("t1_vio2", 32'(bus_a.vio), 32'd0);

    // Interval equal to and above lim
    do_reset();
    bus_a.s1 = 1'b1;
    cyc(10);
    bus_a.s2 = 1'b1;
    cyc(1);
    chk("t2_delta10", 32'(bus_a.last_delta), 32'd10);
    chk("t2_vio10", 32'(bus_a.vio), 32'd0);
    cyc(1);
    bus_a.s2 = 1'b0;
    cyc(3);
    bus_a.s2 = 1'b1;
    cyc(1);
    chk("t2_delta15", 32'(bus_a.last_delta), 32'd15);
    chk("t2_cnt", 32'(bus_a.vio_cnt), 32'd0);

    // s2 activity with no s1 event ever seen
    do_reset();
    bus_a.lim = 16'd100;
    for (int i = 0; i < 6; i++) begin
      bus_a.s2 = ~bus_a.s2;
      cyc(2);
    end
    chk("t3_delta", 32'(bus_a.last_delta), 32'hFFFF);
    chk("t3_cnt", 32'(bus_a.vio_cnt), 32'd0);

    // Shared net, s1 on any edge: the falling edge restarts the interval
    do_reset();
    bus_b.s1 = 1'b1;
    cyc(1);
    chk("t4_delta_first", 32'(bus_b.last_delta), 32'hFFFF);
    cyc(4);
    bus_b.s1 = 1'b0;
    cyc(2);
    bus_b.s1 = 1'b1;
    cyc(1);
    chk("t4_delta", 32'(bus_b.last_delta), 32'd2);
    chk("t4_cnt", 32'(bus_b.vio_cnt), 32'd1);
    chk("t4_vio", 32'(bus_b.vio), 32'd1);

    // Levels high across reset release give no edge
    @(negedge clk);
    rst       = 1'b1;
    bus_a.lim = 16'd5;
    bus_a.s1  = 1'b1;
    bus_a.s2  = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    chk("t5_cnt0", 32'(bus_a.vio_cnt), 32'd0);
    chk("t5_delta0", 32'(bus_a.last_delta), 32'd0);
    bus_a.s1 = 1'b0;
    bus_a.s2 = 1'b0;
    cyc(2);
    bus_a.s1 = 1'b1;
    cyc(2);
    bus_a.s2 = 1'b1;
    cyc(1);
    chk("t5_delta", 32'(bus_a.last_delta), 32'd2);
    chk("t5_cnt", 32'(bus_a.vio_cnt), 32'd1);

    // lim boundaries: all-ones before any s1, then zero
    do_reset();
    bus_a.lim = 16'hFFFF;
    bus_a.s2  = 1'b1;
    cyc(1);
    chk("t7_max_delta", 32'(bus_a.last_delta), 32'hFFFF);
    chk("t7_max_cnt", 32'(bus_a.vio_cnt), 32'd0);
    bus_a.lim = 16'd0;
    bus_a.s2  = 1'b0;
    bus_a.s1  = 1'b1;
    cyc(1);
    bus_a.s2 = 1'b1;
    cyc(1);
    chk("t7_zero_delta", 32'(bus_a.last_delta), 32'd1);
    chk("t7_zero_cnt", 32'(bus_a.vio_cnt), 32'd0);

    // Back-to-back violations on consecutive cycles, then reset mid-pulse
    do_reset();
    bus_c.s1 = 1'b1;
    cyc(3);
    bus_c.s2 = 1'b1;
    cyc(1);
    chk("t6_vio_a", 32'(bus_c.vio), 32'd1);
    chk("t6_cnt1", 32'(bus_c.vio_cnt), 32'd1);
    bus_c.s2 = 1'b0;
    cyc(1);
    chk("t6_vio_b", 32'(bus_c.vio), 32'd1);
    chk("t6_cnt2", 32'(bus_c.vio_cnt), 32'd2);
    chk("t6_delta", 32'(bus_c.last_delta), 32'd4);
    @(posedge clk);
    #1;
    chk("t6_vio_c", 32'(bus_c.vio), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_vio", 32'(bus_c.vio), 32'd0);
    chk("t6_rst_cnt", 32'(bus_c.vio_cnt), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
